tracker_axis_scheduler: RTL and testbench
=========================================

Name: tracker_axis_scheduler

Overview:
Sequences the two-axis solar tracker. On each tracking request it drives theta first, then phi, never both at once. Each axis has a settle wait and a timeout. Sits between the mode switch / periodic tick and the motor driver inputs s_out_theta / s_out_phi. Axis errors come from the photoresistor pairs (automatic mode) or from the manual angle targets (manual mode).

Parameters:
ANGLE_W, 16, width of angle and sensor buses
ERR_BAND, 5, dead band: an error with |error| <= ERR_BAND counts as settled
SETTLE_CYCLES, 1000, clk cycles an axis must stay stopped before it is rechecked
TIMEOUT_CYCLES, 50000, maximum clk cycles spent in one axis move state before fault
DEAD_CYCLES, 200, reversal dead time (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = automatic (photoresistors), 1 = manual (targets)
start  in  1  single-cycle request to begin a tracking cycle; honoured only in IDLE
clear_fault  in  1  clears the sticky fault and returns the block to IDLE
R_vertical_1, R_vertical_2  in  16  vertical photoresistor pair
R_horizontal_1, R_horizontal_2  in  16  horizontal photoresistor pair
theta_manual, phi_manual  in  16  manual targets in degrees, 0..359
theta_actual, phi_actual  in  16  current axis positions in degrees, 0..359
s_out_theta  out  2  theta motor command: 00 stop, 01 clockwise, 11 counter-clockwise
s_out_phi  out  2  phi motor command, same encoding as s_out_theta
busy  out  1  high in every state except IDLE and FAULT
done  out  1  one-cycle pulse when a cycle completes normally
fault  out  1  sticky; high in FAULT
state_dbg  out  3  current state encoding

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; s_out_theta = s_out_phi = 00; busy, done and fault are 0; all counters 0.
- All outputs are registered. A motor command reflects the inputs sampled at the previous clock edge.
- States and transitions:
  - IDLE --start--> MOVE_THETA. On this edge, mode, theta_manual and phi_manual are latched.
  - MOVE_THETA:
    - s_out_theta = direction computed from the theta error; s_out_phi = 00.
    - If the theta error is settled, go to SETTLE_THETA.
  - SETTLE_THETA:
    - Both outputs 00; the settle counter runs.
    - When the count reaches SETTLE_CYCLES, recheck the error: settled goes to MOVE_PHI, not settled goes back to MOVE_THETA.
  - MOVE_PHI / SETTLE_PHI: same as the theta pair, using the phi error. SETTLE_PHI settled goes to DONE.
  - DONE: outputs 00; done = 1 for exactly one cycle; then IDLE.
  - FAULT: outputs 00; fault = 1. Leaves only on clear_fault, to IDLE.
- Automatic error:
  - e = R1 - R2, computed as a 17-bit signed value.
  - Settled when |e| <= ERR_BAND.
  - e > band gives 01; e < -band gives 11.
- Manual error:
  - d = (target - actual + 360) mod 360.
  - Settled when d <= ERR_BAND or d >= 360 - ERR_BAND.
  - d < 180 gives 01; d >= 180 gives 11, so d = 180 resolves to 11.
- Timeout:
  - Each MOVE state counts cycles; the counter resets on entry.
  - Reaching TIMEOUT_CYCLES goes to FAULT.
  - Settle time is not counted toward the timeout.
- Manual target > 359 at the latch edge: go straight to FAULT with no motion.
- start while busy or in FAULT is ignored. A mode change mid-cycle is ignored until the next start.
- clear_fault and start in the same cycle: the clear wins and the start is dropped.
- clear_fault outside FAULT has no effect.
- rst_n low mid-move: outputs go to 00 immediately, asynchronously.

Optional Feature:
TRACKER_DEADTIME_EN.
- Defined: a direction reversal within a MOVE state (01 to 11 or 11 to 01) first drives 00 for DEAD_CYCLES, then the new direction. Dead-time cycles count toward the timeout.
- Undefined: the direction changes on the next edge and DEAD_CYCLES is unused.

Decomposition:
- Package tracker_pkg holds:
  - DIR_STOP = 2'b00, DIR_CW = 2'b01, DIR_CCW = 2'b11
  - ANGLE_FULL = 360, ANGLE_HALF = 180
  - state enum: IDLE, MOVE_THETA, SETTLE_THETA, MOVE_PHI, SETTLE_PHI, DONE, FAULT
- Sub-module axis_error_eval: a combinational evaluator instantiated twice, once per axis.
  - Inputs: mode, sensor pair, target and actual.
  - Outputs: settled and dir.

Test Plan:
- Auto mode, R_vertical_1 = 500, R_vertical_2 = 400, then equal after 20 cycles, horizontal pair equal -> s_out_theta = 01 for 20 cycles; 00 during SETTLE_CYCLES; phi passes without motion; done pulses once; s_out_phi never nonzero.
- Manual mode, theta_actual = 350, theta_manual = 10 -> d = 20, s_out_theta = 01. With theta_actual = 10 and theta_manual = 350 -> 11. With d = 180 -> 11.
- Theta held unsettled -> FAULT after exactly TIMEOUT_CYCLES in MOVE_THETA, fault = 1 and outputs 00. Then clear_fault -> IDLE.
- theta_manual = 400 in manual mode -> FAULT on the cycle after start with no motion. Also, a start pulse during MOVE_PHI -> no effect.
- Error settles, then drifts out of band during SETTLE_THETA -> returns to MOVE_THETA after the settle count.
- Reset asserted mid-MOVE_PHI -> outputs 00 and IDLE asynchronously. With TRACKER_DEADTIME_EN: a 01 to 11 reversal shows exactly DEAD_CYCLES of 00 before 11.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared motor-direction codes, angle constants and scheduler state encoding
// for the two-axis solar tracker.
package tracker_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b11;

  localparam int unsigned ANGLE_FULL = 360;
  localparam int unsigned ANGLE_HALF = 180;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    MOVE_THETA   = 3'd1,
    SETTLE_THETA = 3'd2,
    MOVE_PHI     = 3'd3,
    SETTLE_PHI   = 3'd4,
    DONE         = 3'd5,
    FAULT        = 3'd6
  } state_t;

  function automatic logic is_move(input state_t s);
    return (s == MOVE_THETA) || (s == MOVE_PHI);
  endfunction

endpackage

// File: rtl/axis_error_eval.sv
// Combinational per-axis error evaluator: photoresistor difference in automatic
// mode, wrapped angular distance to the target in manual mode.
module axis_error_eval
  import tracker_pkg::*;
#(
  parameter int unsigned ANGLE_W  = 16,
  parameter int unsigned ERR_BAND = 5
) (
  input  logic               i_mode,
  input  logic [ANGLE_W-1:0] i_r1,
  input  logic [ANGLE_W-1:0] i_r2,
  input  logic [ANGLE_W-1:0] i_target,
  input  logic [ANGLE_W-1:0] i_actual,
  output logic               o_settled,
  output logic [1:0]         o_dir
);

  localparam int unsigned EW = ANGLE_W + 1;
  localparam int unsigned DW = ANGLE_W + 2;

  localparam logic [EW-1:0] BAND_E = EW'(ERR_BAND);
  localparam logic [DW-1:0] FULL_D = DW'(ANGLE_FULL);
  localparam logic [DW-1:0] HALF_D = DW'(ANGLE_HALF);
  localparam logic [DW-1:0] BAND_D = DW'(ERR_BAND);
  localparam logic [DW-1:0] HI_D   = DW'(ANGLE_FULL - ERR_BAND);

  logic [EW-1:0] w_diff;
  logic          w_neg;
  logic [EW-1:0] w_abs;
  logic          w_auto_set;
  logic [1:0]    w_auto_dir;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_d;
  logic          w_man_set;
  logic [1:0]    w_man_dir;

  // Two's-complement difference; the MSB is the sign of the 17-bit error.
  assign w_diff     = {1'b0, i_r1} - {1'b0, i_r2};
  assign w_neg      = w_diff[EW-1];
  assign w_abs      = w_neg ? (~w_diff + EW'(1)) : w_diff;
  assign w_auto_set = (w_abs <= BAND_E);
  assign w_auto_dir = w_auto_set ? DIR_STOP : (w_neg ? DIR_CCW : DIR_CW);

  // Both angles lie in 0..359, so one conditional subtract implements the modulo.
  assign w_sum      = {2'b00, i_target} + FULL_D - {2'b00, i_actual};
  assign w_d        = (w_sum >= FULL_D) ? (w_sum - FULL_D) : w_sum;
  assign w_man_set  = (w_d <= BAND_D) || (w_d >= HI_D);
  assign w_man_dir  = w_man_set ? DIR_STOP : ((w_d < HALF_D) ? DIR_CW : DIR_CCW);

  assign o_settled  = i_mode ? w_man_set : w_auto_set;
  assign o_dir      = i_mode ? w_man_dir : w_auto_dir;

endmodule

// File: rtl/tracker_axis_scheduler.sv
// Two-axis tracker sequencer: theta then phi, each with settle wait and timeout.
// Optional reversal dead time enabled by defining TRACKER_DEADTIME_EN.
module tracker_axis_scheduler
  import tracker_pkg::*;
#(
  parameter int unsigned ANGLE_W        = 16,
  parameter int unsigned ERR_BAND       = 5,
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned DEAD_CYCLES    = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               start,
  input  logic               clear_fault,
  input  logic [ANGLE_W-1:0] R_vertical_1,
  input  logic [ANGLE_W-1:0] R_vertical_2,
  input  logic [ANGLE_W-1:0] R_horizontal_1,
  input  logic [ANGLE_W-1:0] R_horizontal_2,
  input  logic [ANGLE_W-1:0] theta_manual,
  input  logic [ANGLE_W-1:0] phi_manual,
  input  logic [ANGLE_W-1:0] theta_actual,
  input  logic [ANGLE_W-1:0] phi_actual,
  output logic [1:0]         s_out_theta,
  output logic [1:0]         s_out_phi,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [2:0]         state_dbg
);

  localparam int unsigned TCW     = $clog2(TIMEOUT_CYCLES + 1);
  // Settle waits and dead time never overlap, so they share one counter.
  localparam int unsigned AUX_MAX = (SETTLE_CYCLES > DEAD_CYCLES) ? SETTLE_CYCLES : DEAD_CYCLES;
  localparam int unsigned ACW     = $clog2(AUX_MAX + 1);

  localparam logic [TCW-1:0]     T_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [ACW-1:0]     S_LAST  = ACW'(SETTLE_CYCLES - 1);
  localparam logic [ANGLE_W-1:0] TGT_MAX = ANGLE_W'(ANGLE_FULL - 1);
`ifdef TRACKER_DEADTIME_EN
  localparam logic [ACW-1:0]     D_LAST  = ACW'(DEAD_CYCLES - 1);
`endif

  state_t             r_state;
  state_t             w_next;
  logic               r_mode;
  logic [ANGLE_W-1:0] r_theta_tgt;
  logic [ANGLE_W-1:0] r_phi_tgt;
  logic [TCW-1:0]     r_tcnt;
  logic [TCW-1:0]     w_tcnt_n;
  logic [ACW-1:0]     r_acnt;
  logic [ACW-1:0]     w_acnt_n;
  logic [1:0]         r_out_theta;
  logic [1:0]         r_out_phi;
  logic               r_busy;
  logic               r_done;
  logic               r_fault;

  logic               w_mode;
  logic [ANGLE_W-1:0] w_theta_tgt;
  logic [ANGLE_W-1:0] w_phi_tgt;
  logic               w_tgt_bad;
  logic               w_stay;
  logic [1:0]         w_axis_dir;
  logic [1:0]         w_cmd;
  logic               w_th_set;
  logic [1:0]         w_th_dir;
  logic               w_ph_set;
  logic [1:0]         w_ph_dir;
`ifdef TRACKER_DEADTIME_EN
  logic [1:0]         r_last_dir;
  logic [1:0]         w_last_n;
  logic               r_dead_act;
  logic               w_dead_n;
`endif

  // In IDLE the evaluators see the live request so the first command is ready on the start edge.
  assign w_mode      = (r_state == IDLE) ? mode         : r_mode;
  assign w_theta_tgt = (r_state == IDLE) ? theta_manual : r_theta_tgt;
  assign w_phi_tgt   = (r_state == IDLE) ? phi_manual   : r_phi_tgt;
  assign w_tgt_bad   = mode && ((theta_manual > TGT_MAX) || (phi_manual > TGT_MAX));

  axis_error_eval #(
    .ANGLE_W (ANGLE_W),
    .ERR_BAND(ERR_BAND)
  ) u_theta_eval (
    .i_mode   (w_mode),
    .i_r1     (R_vertical_1),
    .i_r2     (R_vertical_2),
    .i_target (w_theta_tgt),
    .i_actual (theta_actual),
    .o_settled(w_th_set),
    .o_dir    (w_th_dir)
  );

  axis_error_eval #(
    .ANGLE_W (ANGLE_W),
    .ERR_BAND(ERR_BAND)
  ) u_phi_eval (
    .i_mode   (w_mode),
    .i_r1     (R_horizontal_1),
    .i_r2     (R_horizontal_2),
    .i_target (w_phi_tgt),
    .i_actual (phi_actual),
    .o_settled(w_ph_set),
    .o_dir    (w_ph_dir)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = w_tgt_bad ? FAULT : MOVE_THETA;
      end
      MOVE_THETA: begin
        if (w_th_set)              w_next = SETTLE_THETA;
        else if (r_tcnt == T_LAST) w_next = FAULT;
      end
      SETTLE_THETA: begin
        if (r_acnt == S_LAST) w_next = w_th_set ? MOVE_PHI : MOVE_THETA;
      end
      MOVE_PHI: begin
        if (w_ph_set)              w_next = SETTLE_PHI;
        else if (r_tcnt == T_LAST) w_next = FAULT;
      end
      SETTLE_PHI: begin
        if (r_acnt == S_LAST) w_next = w_ph_set ? DONE : MOVE_PHI;
      end
      DONE:    w_next = IDLE;
      FAULT: begin
        if (clear_fault) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_stay   = is_move(r_state) && (w_next == r_state);
    w_tcnt_n = w_stay ? (r_tcnt + TCW'(1)) : '0;
    w_acnt_n = '0;
    if ((w_next == r_state) && ((r_state == SETTLE_THETA) || (r_state == SETTLE_PHI)))
      w_acnt_n = r_acnt + ACW'(1);
    case (w_next)
      MOVE_THETA: w_axis_dir = w_th_dir;
      MOVE_PHI:   w_axis_dir = w_ph_dir;
      default:    w_axis_dir = DIR_STOP;
    endcase
    w_cmd = w_axis_dir;
`ifdef TRACKER_DEADTIME_EN
    w_dead_n = 1'b0;
    w_last_n = w_cmd;
    // A reversal parks the motor for DEAD_CYCLES while remaining in the same MOVE state.
    if (w_stay) begin
      w_last_n = r_last_dir;
      if (r_dead_act) begin
        if (r_acnt != '0) begin
          w_cmd    = DIR_STOP;
          w_acnt_n = r_acnt - ACW'(1);
          w_dead_n = 1'b1;
        end
      end else if ((w_axis_dir != DIR_STOP) && (r_last_dir != DIR_STOP) &&
                   (w_axis_dir != r_last_dir)) begin
        w_cmd    = DIR_STOP;
        w_acnt_n = D_LAST;
        w_dead_n = 1'b1;
      end
      if (w_cmd != DIR_STOP) w_last_n = w_cmd;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_theta_tgt <= '0;
      r_phi_tgt   <= '0;
      r_tcnt      <= '0;
      r_acnt      <= '0;
      r_out_theta <= DIR_STOP;
      r_out_phi   <= DIR_STOP;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
`ifdef TRACKER_DEADTIME_EN
      r_last_dir  <= DIR_STOP;
      r_dead_act  <= 1'b0;
`endif
    end else begin
      r_tcnt      <= w_tcnt_n;
      r_acnt      <= w_acnt_n;
      r_out_theta <= (w_next == MOVE_THETA) ? w_cmd : DIR_STOP;
      r_out_phi   <= (w_next == MOVE_PHI)   ? w_cmd : DIR_STOP;
      r_busy      <= !((w_next == IDLE) || (w_next == FAULT));
      r_done      <= (w_next == DONE);
      r_fault     <= (w_next == FAULT);
`ifdef TRACKER_DEADTIME_EN
      r_last_dir  <= w_last_n;
      r_dead_act  <= w_dead_n;
`endif
      if ((r_state == IDLE) && start) begin
        r_mode      <= mode;
        r_theta_tgt <= theta_manual;
        r_phi_tgt   <= phi_manual;
      end
    end
  end

  assign s_out_theta = r_out_theta;
  assign s_out_phi   = r_out_phi;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault       = r_fault;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_tracker_axis_scheduler.sv
// Scoreboard bench: each test queues the expected sequence of output segments
// (state/commands held for N cycles); a monitor pops one per observed change.
module tb_tracker_axis_scheduler;
  import tracker_pkg::*;

  localparam int unsigned SETTLE = 8;
  localparam int unsigned TOUT   = 40;
  localparam int unsigned DEAD   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic        clear_fault = 1'b0;
  logic [15:0] rv1 = 16'd0, rv2 = 16'd0, rh1 = 16'd0, rh2 = 16'd0;
  logic [15:0] thm = 16'd0, phm = 16'd0, tha = 16'd0, pha = 16'd0;
  logic [1:0]  s_out_theta, s_out_phi;
  logic        busy, done, fault;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  th;
    logic [1:0]  ph;
    int unsigned len;
  } seg_t;
  seg_t exp_q[$];

  typedef struct packed {
    logic        m;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  d;
  } vec_t;
  vec_t vt [13];

  always #5 clk = ~clk;

  tracker_axis_scheduler #(
    .ANGLE_W       (16),
    .ERR_BAND      (5),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TOUT),
    .DEAD_CYCLES   (DEAD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .start         (start),
    .clear_fault   (clear_fault),
    .R_vertical_1  (rv1),
    .R_vertical_2  (rv2),
    .R_horizontal_1(rh1),
    .R_horizontal_2(rh2),
    .theta_manual  (thm),
    .phi_manual    (phm),
    .theta_actual  (tha),
    .phi_actual    (pha),
    .s_out_theta   (s_out_theta),
    .s_out_phi     (s_out_phi),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .state_dbg     (state_dbg)
  );

  function automatic logic [9:0] exp_tup(input seg_t s);
    logic b, d, f;
    b = !((s.st == 3'(IDLE)) || (s.st == 3'(FAULT)));
    d = (s.st == 3'(DONE));
    f = (s.st == 3'(FAULT));
    return {s.st, s.th, s.ph, b, d, f};
  endfunction

  task automatic push(input state_t st, input logic [1:0] th, input logic [1:0] ph,
                      input int unsigned len);
    seg_t s;
    s.st = st; s.th = th; s.ph = ph; s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic phi_tail();
    push(SETTLE_THETA, DIR_STOP, DIR_STOP, SETTLE);
    push(MOVE_PHI,     DIR_STOP, DIR_STOP, 1);
    push(SETTLE_PHI,   DIR_STOP, DIR_STOP, SETTLE);
    push(DONE,         DIR_STOP, DIR_STOP, 1);
    push(IDLE,         DIR_STOP, DIR_STOP, 0);
  endtask

  task automatic check_seg(input logic [9:0] act, input int unsigned run);
    seg_t       e;
    logic [9:0] et;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL seg_unexpected act st=%0d th=%b ph=%b bdf=%b len=%0d exp none",
               act[9:7], act[6:5], act[4:3], act[2:0], run);
    end else begin
      e  = exp_q.pop_front();
      et = exp_tup(e);
      if (act != et || (e.len != 0 && e.len != run)) begin
        errors++;
        $display("FAIL seg act st=%0d th=%b ph=%b bdf=%b len=%0d exp st=%0d th=%b ph=%b bdf=%b len=%0d",
                 act[9:7], act[6:5], act[4:3], act[2:0], run,
                 et[9:7], et[6:5], et[4:3], et[2:0], e.len);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  initial begin : monitor
    logic [9:0]  prev, cur;
    int unsigned run;
    wait (mon_en);
    @(negedge clk);
    prev = {state_dbg, s_out_theta, s_out_phi, busy, done, fault};
    run  = 1;
    forever begin
      @(negedge clk);
      cur = {state_dbg, s_out_theta, s_out_phi, busy, done, fault};
      if (cur == prev) run++;
      else begin
        check_seg(prev, run);
        prev = cur;
        run  = 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic run_theta(input vec_t v);
    mode = v.m;
    rh1 = 16'd300; rh2 = 16'd300; phm = 16'd100; pha = 16'd100;
    if (!v.m) begin rv1 = v.a; rv2 = v.b; end
    else      begin thm = v.a; tha = v.b; end
    if (v.d == DIR_STOP) push(MOVE_THETA, DIR_STOP, DIR_STOP, 1);
    else                 push(MOVE_THETA, v.d, DIR_STOP, 3);
    phi_tail();
    pulse_start();
    if (v.d != DIR_STOP) begin
      cyc(2);
      if (!v.m) rv2 = rv1;
      else      tha = thm;
    end
    cyc(25);
  endtask

  initial begin : stim
    vt = '{'{1'b1, 16'd10,  16'd350,   DIR_CW},
           '{1'b1, 16'd350, 16'd10,    DIR_CCW},
           '{1'b1, 16'd190, 16'd10,    DIR_CCW},
           '{1'b1, 16'd189, 16'd10,    DIR_CW},
           '{1'b1, 16'd15,  16'd10,    DIR_STOP},
           '{1'b1, 16'd16,  16'd10,    DIR_CW},
           '{1'b1, 16'd5,   16'd10,    DIR_STOP},
           '{1'b1, 16'd4,   16'd10,    DIR_CCW},
           '{1'b0, 16'd500, 16'd400,   DIR_CW},
           '{1'b0, 16'd405, 16'd400,   DIR_STOP},
           '{1'b0, 16'd400, 16'd406,   DIR_CCW},
           '{1'b0, 16'd400, 16'd405,   DIR_STOP},
           '{1'b0, 16'd0,   16'd65535, DIR_CCW}};

    #2 rst_n = 1'b0;
    #2;
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_theta", 32'(s_out_theta), 0);
    chk("rst_phi",   32'(s_out_phi), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    cyc(2);
    rst_n = 1'b1;
    push(IDLE, DIR_STOP, DIR_STOP, 0);
    mon_en = 1'b1;
    cyc(3);

    // Automatic: theta drives clockwise for 20 cycles, phi already centred.
    mode = 1'b0; rv1 = 16'd500; rv2 = 16'd400; rh1 = 16'd300; rh2 = 16'd300;
    push(MOVE_THETA, DIR_CW, DIR_STOP, 20);
    phi_tail();
    pulse_start();
    cyc(19);
    rv2 = 16'd500;
    cyc(25);

    foreach (vt[i]) run_theta(vt[i]);

    // Timeout, start ignored in FAULT, clear beats start, clear in IDLE harmless.
    mode = 1'b1; thm = 16'd90; tha = 16'd0; phm = 16'd100; pha = 16'd100;
    push(MOVE_THETA, DIR_CW, DIR_STOP, TOUT);
    push(FAULT, DIR_STOP, DIR_STOP, 3);
    push(IDLE, DIR_STOP, DIR_STOP, 0);
    pulse_start();
    cyc(40);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    clear_fault = 1'b1; start = 1'b1;
    cyc(1);
    clear_fault = 1'b0; start = 1'b0;
    tha = 16'd90;
    cyc(3);
    clear_fault = 1'b1;
    cyc(2);
    clear_fault = 1'b0;
    cyc(3);

    // Out-of-range manual targets fault on the cycle after start.
    thm = 16'd400; tha = 16'd0;
    push(FAULT, DIR_STOP, DIR_STOP, 1);
    push(IDLE, DIR_STOP, DIR_STOP, 0);
    pulse_start();
    clear_fault = 1'b1;
    cyc(1);
    clear_fault = 1'b0;
    cyc(3);
    thm = 16'd10; tha = 16'd10; phm = 16'd360;
    push(FAULT, DIR_STOP, DIR_STOP, 1);
    push(IDLE, DIR_STOP, DIR_STOP, 0);
    pulse_start();
    clear_fault = 1'b1;
    cyc(1);
    clear_fault = 1'b0;
    phm = 16'd0; pha = 16'd0; thm = 16'd0; tha = 16'd0;
    cyc(3);

    // Start and mode flip during MOVE_PHI must be ignored.
    mode = 1'b0; rv1 = 16'd500; rv2 = 16'd500; rh1 = 16'd300; rh2 = 16'd400;
    push(MOVE_THETA, DIR_STOP, DIR_STOP, 1);
    push(SETTLE_THETA, DIR_STOP, DIR_STOP, SETTLE);
    push(MOVE_PHI, DIR_STOP, DIR_CCW, 4);
    push(SETTLE_PHI, DIR_STOP, DIR_STOP, SETTLE);
    push(DONE, DIR_STOP, DIR_STOP, 1);
    push(IDLE, DIR_STOP, DIR_STOP, 0);
    pulse_start();
    cyc(9);
    start = 1'b1; mode = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    rh2 = 16'd300;
    cyc(25);
    mode = 1'b0;

    // Drift out of band during SETTLE_THETA returns to MOVE_THETA.
    rv1 = 16'd500; rv2 = 16'd500; rh1 = 16'd300; rh2 = 16'd300;
    push(MOVE_THETA, DIR_STOP, DIR_STOP, 1);
    push(SETTLE_THETA, DIR_STOP, DIR_STOP, SETTLE);
    push(MOVE_THETA, DIR_CW, DIR_STOP, 2);
    phi_tail();
    pulse_start();
    cyc(2);
    rv1 = 16'd600;
    cyc(8);
    rv1 = 16'd500;
    cyc(25);

    // Asynchronous reset in the middle of MOVE_PHI.
    rh1 = 16'd400; rh2 = 16'd300;
    push(MOVE_THETA, DIR_STOP, DIR_STOP, 1);
    push(SETTLE_THETA, DIR_STOP, DIR_STOP, SETTLE);
    push(MOVE_PHI, DIR_STOP, DIR_CW, 2);
    push(IDLE, DIR_STOP, DIR_STOP, 0);
    pulse_start();
    cyc(9);
    chk("pre_rst_phi", 32'(s_out_phi), 32'(DIR_CW));
    cyc(2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_phi",   32'(s_out_phi), 0);
    chk("arst_theta", 32'(s_out_theta), 0);
    chk("arst_state", 32'(state_dbg), 32'(IDLE));
    chk("arst_busy",  32'(busy), 0);
    cyc(2);
    rst_n = 1'b1;
    rh2 = 16'd400;
    cyc(5);

    // Manual reversal 01 -> 11 inside MOVE_THETA.
    mode = 1'b1; thm = 16'd90; tha = 16'd0; phm = 16'd100; pha = 16'd100;
    push(MOVE_THETA, DIR_CW, DIR_STOP, 3);
`ifdef TRACKER_DEADTIME_EN
    push(MOVE_THETA, DIR_STOP, DIR_STOP, DEAD);
    push(MOVE_THETA, DIR_CCW, DIR_STOP, 2);
`else
    push(MOVE_THETA, DIR_CCW, DIR_STOP, 6);
`endif
    phi_tail();
    pulse_start();
    cyc(2);
    tha = 16'd180;
    cyc(6);
    tha = 16'd90;
    cyc(25);

    cyc(5);
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL leftover_segments act=%0d exp=1", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
